mef_n_select: RTL and testbench
===============================

Name: mef_n_select

Overview:
- Parametrised successor to the two-input NADA/ASP/GOT selector FSM.
- Tracks which one of N_CH request inputs is exclusively active and reports it as a state code, with 0 meaning NADA (idle).
- Adds an input stability filter, a sticky mode, conflict reporting, a change strobe and a dwell counter.
- Sits between raw sensor or request lines and downstream display/actuator logic.

Parameters:
- N_CH, 2: number of request channels; must be >= 2.
- DEB_CYC, 1: consecutive rising edges an input pattern must hold before it is acted on; must be >= 1. A value of 1 gives legacy behaviour.
- DWELL_W, 8: width of the dwell counter.
- CODE_W (derived localparam): $clog2(N_CH+1). Not overridable.

Ports:
- CLK  in  1  system clock, rising edge.
- reset  in  1  synchronous active-low reset. It is sampled on the CLK rising edge; 0 = reset.
- sel_in  in  N_CH  request lines. Bit k requests channel k.
- sticky  in  1  mode select. 1 = hold the last channel when all inputs drop; 0 = return to NADA.
- cout  out  CODE_W  registered state code. 0 = NADA; k+1 = channel k.
- idle  out  1  registered; 1 when cout == 0.
- chg  out  1  one-cycle pulse, high in the first cycle cout shows a new value.
- conflict  out  1  registered; 1 when the most recently qualified pattern had two or more bits set.
- dwell  out  DWELL_W  cycles since the last cout change; saturates at 2^DWELL_W-1.

Behaviour:
- Reset (reset==0 at a CLK edge):
  - cout=0, idle=1, chg=0, conflict=0, dwell=0.
  - The stability history is cleared.
  - Reset overrides all other activity, including mid-debounce and mid-dwell.
- Pattern classification of sel_in:
  - ZERO: no bits set.
  - ONE(k): exactly bit k set.
  - MULTI: two or more bits set.
- Qualification:
  - A pattern is qualified at the edge where sel_in has held the identical value for DEB_CYC consecutive rising edges, counting that edge.
  - If the pattern changes, counting restarts at 1 with the new value.
  - While the pattern stays constant, every subsequent edge is also a qualifying edge.
  - With DEB_CYC=1, every edge qualifies, giving one-cycle latency from sel_in to cout.
  - After reset release, the first qualification needs DEB_CYC fresh edges. No sample taken during reset counts.
- State update on a qualifying edge:
  - ONE(k): cout <= k+1.
  - ZERO with sticky=0: cout <= 0.
  - ZERO with sticky=1: cout holds.
  - MULTI: cout holds and conflict <= 1.
  - conflict <= 0 on any qualified ZERO or ONE.
- Non-qualifying edges: cout and conflict hold.
- sticky is sampled directly, without filtering, and is only consulted on qualifying edges.
- chg: registered. It is 1 exactly on the edge at which cout takes a value different from its prior value, otherwise 0. A qualified update that keeps the same code does not pulse chg.
- dwell:
  - Set to 0 on any edge where cout changes.
  - Otherwise increments by 1 per edge, saturating (no wrap).
- idle is registered alongside cout and is never out of step with it.
- Next-state logic is fully specified for every input value. No latches and no X propagation. Unused code values (> N_CH) are unreachable, and recover to 0 on the next qualifying edge if ever present.

Decomposition:
- Package mef_pkg:
  - constant CODE_NADA = 0
  - pattern enum {PAT_ZERO, PAT_ONE, PAT_MULTI}
  - function chan_to_code(k) = k+1
  - onehot/popcount-classification function, parametrised by width
- Sub-module mef_debounce:
  - parameters: N_CH, DEB_CYC
  - inputs: CLK, reset, sel_in
  - outputs: qualify strobe and the qualified vector
- The top block holds the selection FSM, conflict, chg and dwell logic.

Test Plan:
1. Legacy configuration (N_CH=2, DEB_CYC=1, sticky=0):
   - sel_in=01 -> cout=1 after 1 edge.
   - then 11 -> cout stays 1, conflict=1.
   - then 10 -> cout=2, chg pulse, conflict=0.
   - then 00 -> cout=0, idle=1.
2. Glitch rejection (N_CH=4, DEB_CYC=3):
   - sel_in=0100 for 2 edges, then 0000 -> cout remains 0, chg never asserts.
   - 0100 held 3 edges -> cout=3 on the third edge, chg high for exactly 1 cycle.
3. Sticky mode (N_CH=4, DEB_CYC=1, sticky=1):
   - sel_in 0010 -> cout=2.
   - then 0000 for 10 edges -> cout stays 2, dwell counts to 10.
   - then 1000 -> cout=4, dwell=0.
4. Reset mid-operation (N_CH=4, DEB_CYC=3, cout=3, dwell=17, debounce mid-count):
   - reset=0 for 1 edge -> cout=0, idle=1, dwell=0, conflict=0.
   - sel_in held 0001 from release -> cout=1 only on the 3rd post-reset edge.
5. Dwell saturation (DWELL_W=4):
   - constant sel_in for 20 edges after a change -> dwell reads 15 and holds.
   - next change -> dwell=0.
6. Multi hold (N_CH=3, DEB_CYC=2):
   - from cout=1, sel_in=011 held 2 edges -> cout=1, conflict=1, no chg.
   - then 000 held 2 edges -> cout=0, conflict=0.

Source files
------------

// File: rtl/mef_pkg.sv
// Shared constants, pattern classification and code helpers for the
// exclusive-channel selector.
package mef_pkg;

  localparam int unsigned CODE_NADA = 0;
  localparam int unsigned MaxCh     = 32;

  typedef enum logic [1:0] {
    PatZero,
    PatOne,
    PatMulti
  } pat_e;

  function automatic int unsigned chan_to_code(input int unsigned k);
    return k + 1;
  endfunction

  // Only the low `width` bits of v take part in the classification.
  function automatic pat_e classify(input logic [MaxCh-1:0] v, input int width);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MaxCh; i++) begin
      if (i < width && v[i]) cnt = cnt + 1;
    end
    if (cnt == 0)      return PatZero;
    else if (cnt == 1) return PatOne;
    else               return PatMulti;
  endfunction

  function automatic int unsigned low_idx(input logic [MaxCh-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/mef_debounce.sv
// Stability filter: flags every edge at which sel_in has held one value for
// DEB_CYC consecutive edges (counting the current one).
module mef_debounce #(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DEB_CYC = 1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [N_CH-1:0] sel_in,
  output logic            qual_o,
  output logic [N_CH-1:0] qual_vec_o
);

  localparam int unsigned CntW = (DEB_CYC < 2) ? 1 : $clog2(DEB_CYC + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC);

  logic [N_CH-1:0] hist_q, hist_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // cnt_q == 0 means no usable history (just out of reset).
  always_comb begin
    hist_d = sel_in;
    cnt_d  = CntW'(1);
    if (cnt_q != '0 && sel_in == hist_q) begin
      cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
    end
  end

  assign qual_o     = (cnt_d == CntMax);
  assign qual_vec_o = sel_in;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/mef_n_select.sv
// N-channel exclusive selector: reports which request line is solely active,
// with debounce, sticky hold, conflict flag, change strobe and dwell counter.
module mef_n_select
  import mef_pkg::*;
#(
  parameter int unsigned N_CH    = 2,
  parameter int unsigned DEB_CYC = 1,
  parameter int unsigned DWELL_W = 8
) (
  input  logic                        CLK,
  input  logic                        reset,
  input  logic [N_CH-1:0]             sel_in,
  input  logic                        sticky,
  output logic [$clog2(N_CH+1)-1:0]   cout,
  output logic                        idle,
  output logic                        chg,
  output logic                        conflict,
  output logic [DWELL_W-1:0]          dwell
);

  localparam int unsigned CODE_W = $clog2(N_CH + 1);

  logic              qual;
  logic [N_CH-1:0]   qual_vec;
  pat_e              pat;
  logic [CODE_W-1:0] cout_q, cout_d;
  logic              conflict_q, conflict_d;
  logic              chg_q, chg_d;
  logic              idle_q, idle_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  mef_debounce #(
    .N_CH    (N_CH),
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .CLK        (CLK),
    .reset      (reset),
    .sel_in     (sel_in),
    .qual_o     (qual),
    .qual_vec_o (qual_vec)
  );

  assign pat = classify(MaxCh'(qual_vec), int'(N_CH));

  always_comb begin
    cout_d     = cout_q;
    conflict_d = conflict_q;
    if (qual) begin
      unique case (pat)
        PatZero: begin
          conflict_d = 1'b0;
          if (!sticky) cout_d = CODE_W'(CODE_NADA);
        end
        PatOne: begin
          conflict_d = 1'b0;
          cout_d     = CODE_W'(chan_to_code(low_idx(MaxCh'(qual_vec))));
        end
        PatMulti: conflict_d = 1'b1;
        default:  conflict_d = 1'b1;
      endcase
      // Out-of-range codes are unreachable; scrub them if ever seen.
      if (cout_d > CODE_W'(N_CH)) cout_d = CODE_W'(CODE_NADA);
    end
    chg_d   = (cout_d != cout_q);
    idle_d  = (cout_d == CODE_W'(CODE_NADA));
    dwell_d = chg_d ? '0 : ((&dwell_q) ? dwell_q : dwell_q + DWELL_W'(1));
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      cout_q     <= '0;
      conflict_q <= 1'b0;
      chg_q      <= 1'b0;
      idle_q     <= 1'b1;
      dwell_q    <= '0;
    end else begin
      cout_q     <= cout_d;
      conflict_q <= conflict_d;
      chg_q      <= chg_d;
      idle_q     <= idle_d;
      dwell_q    <= dwell_d;
    end
  end

  assign cout     = cout_q;
  assign conflict = conflict_q;
  assign chg      = chg_q;
  assign idle     = idle_q;
  assign dwell    = dwell_q;

endmodule

// File: tb/tb_mef_n_select.sv
// Randomised and directed bench for mef_n_select, two configurations side by
// side, checked against a behavioural model.
module tb_mef_n_select;

  logic       CLK = 1'b0;
  logic       reset;
  logic       sticky;
  logic [1:0] sel_a;
  logic [3:0] sel_b;

  logic [1:0] cout_a;
  logic       idle_a, chg_a, conflict_a;
  logic [7:0] dwell_a;
  logic [2:0] cout_b;
  logic       idle_b, chg_b, conflict_b;
  logic [3:0] dwell_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  mef_n_select #(.N_CH(2), .DEB_CYC(1), .DWELL_W(8)) u_dut_a (
    .CLK      (CLK),
    .reset    (reset),
    .sel_in   (sel_a),
    .sticky   (sticky),
    .cout     (cout_a),
    .idle     (idle_a),
    .chg      (chg_a),
    .conflict (conflict_a),
    .dwell    (dwell_a)
  );

  mef_n_select #(.N_CH(4), .DEB_CYC(3), .DWELL_W(4)) u_dut_b (
    .CLK      (CLK),
    .reset    (reset),
    .sel_in   (sel_b),
    .sticky   (sticky),
    .cout     (cout_b),
    .idle     (idle_b),
    .chg      (chg_b),
    .conflict (conflict_b),
    .dwell    (dwell_b)
  );

  typedef struct {
    int last;
    int held;
    int cout;
    int conf;
    int chg;
    int dwell;
  } mdl_t;

  mdl_t ma, mb;

  // One clock edge of the behavioural model.
  function automatic void mstep(inout mdl_t s, input int n, input int deb, input int dmax,
                                input bit rst_n, input int sel, input bit stk);
    int bits, idx, nxt;
    if (!rst_n) begin
      s.held = 0; s.last = 0; s.cout = 0; s.conf = 0; s.chg = 0; s.dwell = 0;
      return;
    end
    s.held = (s.held > 0 && sel == s.last) ? s.held + 1 : 1;
    s.last = sel;
    nxt = s.cout;
    if (s.held >= deb) begin
      bits = 0; idx = 0;
      for (int i = n - 1; i >= 0; i--) if ((sel >> i) & 1) begin bits++; idx = i; end
      if (bits == 0) begin s.conf = 0; if (!stk) nxt = 0; end
      else if (bits == 1) begin s.conf = 0; nxt = idx + 1; end
      else s.conf = 1;
    end
    s.chg   = (nxt != s.cout) ? 1 : 0;
    s.dwell = s.chg ? 0 : ((s.dwell < dmax) ? s.dwell + 1 : dmax);
    s.cout  = nxt;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    mstep(ma, 2, 1, 255, reset, int'(sel_a), sticky);
    mstep(mb, 4, 3, 15,  reset, int'(sel_b), sticky);
    @(posedge CLK);
    #1;
    check("a.cout",     32'(cout_a),     ma.cout);
    check("a.idle",     32'(idle_a),     (ma.cout == 0) ? 1 : 0);
    check("a.chg",      32'(chg_a),      ma.chg);
    check("a.conflict", 32'(conflict_a), ma.conf);
    check("a.dwell",    32'(dwell_a),    ma.dwell);
    check("b.cout",     32'(cout_b),     mb.cout);
    check("b.idle",     32'(idle_b),     (mb.cout == 0) ? 1 : 0);
    check("b.chg",      32'(chg_b),      mb.chg);
    check("b.conflict", 32'(conflict_b), mb.conf);
    check("b.dwell",    32'(dwell_b),    mb.dwell);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    reset = 1'b0; sticky = 1'b0; sel_a = '0; sel_b = '0;
    ticks(2);
    check("rst.cout_b",  32'(cout_b),  0);
    check("rst.idle_b",  32'(idle_b),  1);
    check("rst.dwell_b", 32'(dwell_b), 0);
    reset = 1'b1;

    // Legacy walk on the 2-channel, no-debounce instance.
    sel_a = 2'b01; tick(); check("leg.cout1", 32'(cout_a), 1);
    sel_a = 2'b11; tick(); check("leg.conf",  32'(conflict_a), 1);
    check("leg.hold", 32'(cout_a), 1);
    sel_a = 2'b10; tick(); check("leg.cout2", 32'(cout_a), 2);
    check("leg.chg", 32'(chg_a), 1);
    check("leg.conf0", 32'(conflict_a), 0);
    sel_a = 2'b00; tick(); check("leg.idle", 32'(idle_a), 1);

    // Glitch rejection, then a clean 3-edge hold.
    sel_b = 4'b0100; ticks(2);
    sel_b = 4'b0000; tick();
    check("glitch.cout", 32'(cout_b), 0);
    sel_b = 4'b0100; ticks(2);
    check("deb.early", 32'(cout_b), 0);
    tick();
    check("deb.cout", 32'(cout_b), 3);
    check("deb.chg",  32'(chg_b), 1);
    tick();
    check("deb.chg1cyc", 32'(chg_b), 0);

    // Sticky hold with dwell saturation, then a new channel.
    sticky = 1'b1;
    sel_b = 4'b0010; ticks(3);
    sel_b = 4'b0000; ticks(20);
    check("stk.cout",  32'(cout_b),  2);
    check("stk.dwsat", 32'(dwell_b), 15);
    sel_b = 4'b1000; ticks(3);
    check("stk.new", 32'(cout_b), 4);
    check("stk.dw0", 32'(dwell_b), 0);
    sticky = 1'b0;

    // Reset mid-debounce.
    sel_b = 4'b0010; ticks(1);
    reset = 1'b0; tick(); reset = 1'b1;
    check("rmid.cout", 32'(cout_b), 0);
    sel_b = 4'b0001; ticks(2);
    check("rmid.early", 32'(cout_b), 0);
    tick();
    check("rmid.cout1", 32'(cout_b), 1);

    // Random held segments with occasional reset and sticky flips.
    for (int seg = 0; seg < 1500; seg++) begin
      sel_a  = 2'($urandom);
      sel_b  = 4'($urandom);
      if ($urandom_range(0, 3) == 0) sel_b = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) sticky = ~sticky;
      reset  = ($urandom_range(0, 60) != 0);
      tick();
      reset  = 1'b1;
      ticks($urandom_range(0, 4));
      if ($urandom_range(0, 30) == 0) ticks(18);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
